mult_seq_param: RTL and testbench
=================================

Name: mult_seq_param

Overview:
- Parametrised sequential shift-add multiplier; next generation of the team's 32-bit multiplicador.
- Adds:
  - configurable operand width;
  - configurable bits retired per cycle (radix 2^STEP);
  - run-time signed/unsigned mode;
  - a busy indicator.
- Keeps the valid_data / Done_Flag / ack / ret_ack handshake, so existing testers drive it unchanged.
- Sits between a requesting datapath/tester and any consumer of a 2*WIDTH product.

Parameters:
- WIDTH, 32, operand width in bits; must be >= 2.
- STEP, 1, multiplier bits consumed per CALC cycle; WIDTH % STEP must be 0; legal 1..WIDTH.

Ports:
- clk  input  1  single clock, all state updates on rising edge.
- reset  input  1  synchronous, active-high; sampled on rising edge of clk.
- a  input  WIDTH  multiplicand; sampled only at the capture edge.
- b  input  WIDTH  multiplier; sampled only at the capture edge.
- signed_mode  input  1  1 = two's-complement operands, 0 = unsigned; sampled at the capture edge.
- valid_data  input  1  request; operands valid while high.
- ack  input  1  consumer has taken producto.
- producto  output  2*WIDTH  registered product.
- Done_Flag  output  1  producto valid; held until ack.
- ret_ack  output  1  one-cycle pulse confirming operand capture.
- busy  output  1  high in CALC and DONE.

Behaviour:
- Reset values (any state, including mid-operation):
  - producto=0, Done_Flag=0, ret_ack=0, busy=0, state=IDLE.
  - Any in-flight operation is discarded; reset has priority over all other inputs.
- States IDLE, CALC, DONE; N = WIDTH/STEP.
- IDLE:
  - At an edge with valid_data=1 (capture edge E0), register the following, then go to CALC:
    - operand magnitudes (|a|, |b| when signed_mode=1, else raw);
    - result sign = a[MSB]^b[MSB] & signed_mode;
    - accumulator=0;
    - step counter=0.
  - ret_ack=1 for exactly the cycle after E0; busy=1 from E0.
- CALC:
  - Each edge: add (multiplicand * low STEP bits of multiplier) to the accumulator.
  - Multiplicand shifts left by STEP; multiplier shifts right by STEP; counter increments.
  - At edge E0+N: producto <= accumulator, two's-negated if result sign=1; Done_Flag=1; go to DONE.
- DONE:
  - producto and Done_Flag held.
  - Edge with ack=1: Done_Flag=0, busy=0, go to IDLE.
- Latency: Done_Flag and new producto visible after edge E0+N (32 cycles for defaults, 8 for WIDTH=32/STEP=4).
- Arithmetic and width rules:
  - Internal magnitudes are WIDTH bits unsigned, so |most-negative| fits.
  - Accumulator is 2*WIDTH bits; no overflow is possible.
  - Signed result is exact for all inputs, e.g. most-negative * most-negative = +2^(2*WIDTH-2).
- Ignored inputs:
  - valid_data outside IDLE is ignored; no queueing.
  - a, b and signed_mode changes after E0 do not affect the running operation.
  - ack in IDLE/CALC is ignored.
- Simultaneous ack and valid_data in DONE: ack wins, go to IDLE. Capture occurs at the next edge if valid_data is still high (earliest back-to-back issue: 1 idle cycle).
- producto keeps its last value after leaving DONE, until overwritten by the next completion or by reset.
- Done_Flag and ret_ack never assert in the same cycle.

Optional Feature:
- Macro MULT_SEQ_EARLY_TERM_EN.
- When defined:
  - At each CALC edge, if the multiplier register after that edge's shift is zero, finish at that same edge (producto load, sign fix, DONE), skipping the remaining steps.
  - Latency becomes ceil((index of highest set bit of |b| + 1)/STEP), minimum 1.
  - The result is identical to fixed-latency operation.
- When undefined: latency is always N.

Test Plan:
- Defaults, unsigned: a=10, b=10, valid_data pulsed after reset → ret_ack one cycle after capture; Done_Flag at E0+32, producto=100; ack → Done_Flag low next edge, busy=0.
- Unsigned: a=b=0xFFFFFFFF → producto=0xFFFFFFFE00000001. Then a=19347, b=0 → producto=0, which checks that producto is not stale.
- Signed, signed_mode=1:
  - a=0xFFFFFFFF, b=0xFFFFFFFF → producto=1.
  - a=0x80000000, b=1 → 0xFFFFFFFF80000000.
  - a=b=0x80000000 → 0x4000000000000000.
- STEP=4, WIDTH=32: a=123456, b=654321 → Done_Flag at E0+8, producto=80779853376. Toggling a/b during CALC leaves the result unchanged.
- Protocol:
  - valid_data held high through CALC and DONE → exactly one capture per ack.
  - ack and valid_data high together in DONE → return to IDLE, recapture next edge.
  - ack during CALC ignored.
- Reset at E0+10 mid-CALC → all outputs 0, IDLE next cycle. A new request afterwards completes correctly. With MULT_SEQ_EARLY_TERM_EN: b=10 (STEP=1) → Done_Flag at E0+4; b=0 → E0+1.

Source files
------------

// File: rtl/mult_seq_param.sv
// ---------------------------------------------------------------------------
// mult_seq_param
//
// Parametrised sequential shift-add multiplier. This is the successor of the
// 32-bit multiplicador. It retires STEP multiplier bits per clock (radix
// 2^STEP) and takes the operand signedness at run time. It keeps the
// valid_data / ret_ack / Done_Flag / ack handshake of the older block.
//
// Parameters
//   WIDTH  operand width in bits (>= 2)
//   STEP   multiplier bits consumed per CALC cycle (WIDTH % STEP == 0)
//
// Ports
//   clk          single clock, everything updates on the rising edge
//   reset        synchronous, active-high, priority over all other inputs
//   a            multiplicand, sampled only at the capture edge
//   b            multiplier, sampled only at the capture edge
//   signed_mode  1 = two's-complement operands, 0 = unsigned
//   valid_data   request; operands are valid while high
//   ack          consumer has taken producto
//   producto     registered 2*WIDTH-bit product
//   Done_Flag    producto valid; held until ack
//   ret_ack      one-cycle pulse in the cycle after operand capture
//   busy         high while in CALC or DONE
//
// Optional feature
//   MULT_SEQ_EARLY_TERM_EN  when defined, the block finishes as soon as the
//   remaining multiplier bits are all zero. Latency then becomes
//   ceil((msb index of |b| + 1) / STEP), with a minimum of 1. The result is
//   the same as with the fixed latency.
// ---------------------------------------------------------------------------
module mult_seq_param #(
  parameter int WIDTH = 32,
  parameter int STEP  = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               signed_mode,
  input  logic               valid_data,
  input  logic               ack,
  output logic [2*WIDTH-1:0] producto,
  output logic               Done_Flag,
  output logic               ret_ack,
  output logic               busy
);

  localparam int N     = WIDTH / STEP;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               neg_q, neg_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic               ret_ack_q, ret_ack_d;

  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [2*WIDTH-1:0] partial;
  logic [2*WIDTH-1:0] acc_sum;
  logic [WIDTH-1:0]   mplier_shifted;
  logic               finish;

  // Operands are stored as unsigned magnitudes. A WIDTH-bit unsigned
  // magnitude still holds |most-negative|, so the datapath never needs an
  // extra bit. The sign is applied once, when the result is loaded.
  always_comb begin
    a_mag = (signed_mode && a[WIDTH-1]) ? -a : a;
    b_mag = (signed_mode && b[WIDTH-1]) ? -b : b;
  end

  // This is the radix-2^STEP partial product. It is the shifted multiplicand
  // gated by each of the low STEP multiplier bits.
  always_comb begin
    partial = '0;
    for (int i = 0; i < STEP; i++) begin
      if (mplier_q[i]) begin
        partial = partial + (mcand_q << i);
      end
    end
    acc_sum        = acc_q + partial;
    mplier_shifted = mplier_q >> STEP;
  end

  // The last CALC edge is normally fixed by the step counter. With early
  // termination, the block also stops once no multiplier bits are left.
  always_comb begin
`ifdef MULT_SEQ_EARLY_TERM_EN
    finish = (cnt_q == LAST_CNT) || (mplier_shifted == '0);
`else
    finish = (cnt_q == LAST_CNT);
`endif
  end

  // This process holds the next-state and datapath-update logic. Every
  // register holds its value unless the current state says otherwise.
  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    neg_d     = neg_q;
    prod_d    = prod_q;
    ret_ack_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (valid_data) begin
          mcand_d   = {{WIDTH{1'b0}}, a_mag};
          mplier_d  = b_mag;
          acc_d     = '0;
          cnt_d     = '0;
          neg_d     = signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
          ret_ack_d = 1'b1;
          state_d   = CALC;
        end
      end

      CALC: begin
        acc_d    = acc_sum;
        mcand_d  = mcand_q << STEP;
        mplier_d = mplier_shifted;
        cnt_d    = cnt_q + CNT_ONE;
        if (finish) begin
          prod_d  = neg_q ? -acc_sum : acc_sum;
          state_d = DONE;
        end
      end

      DONE: begin
        // ack takes priority over valid_data. A new capture can only
        // happen from IDLE on a later edge.
        if (ack) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // This is the state register. Reset drops any operation in flight and
  // clears the visible product.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      neg_q     <= 1'b0;
      prod_q    <= '0;
      ret_ack_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      neg_q     <= neg_d;
      prod_q    <= prod_d;
      ret_ack_q <= ret_ack_d;
    end
  end

  // All outputs come from registered state. ret_ack is high only in the
  // first CALC cycle and Done_Flag only in DONE, so they never overlap.
  always_comb begin
    producto  = prod_q;
    Done_Flag = (state_q == DONE);
    ret_ack   = ret_ack_q;
    busy      = (state_q != IDLE);
  end

endmodule

// File: tb/tb_mult_seq_param.sv
// ---------------------------------------------------------------------------
// tb_mult_seq_param
//
// Self-checking bench for mult_seq_param. Two instances share the clock,
// reset and operand buses: dut1 uses the defaults (WIDTH=32, STEP=1) and
// dut4 uses WIDTH=32, STEP=4. The sel signal steers valid_data/ack to one of
// them and picks which outputs are observed. Expected products and latencies
// come from a plain-arithmetic reference model.
// ---------------------------------------------------------------------------
module tb_mult_seq_param;

`ifdef MULT_SEQ_EARLY_TERM_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] a;
  logic [31:0] b;
  logic        signed_mode;
  logic        valid_data;
  logic        ack;
  logic        sel;

  logic        valid_1, valid_4, ack_1, ack_4;
  logic [63:0] prod_1, prod_4;
  logic        done_1, done_4, rack_1, rack_4, busy_1, busy_4;

  logic [63:0] cur_prod;
  logic        cur_done, cur_rack, cur_busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign valid_1  = valid_data & ~sel;
  assign valid_4  = valid_data &  sel;
  assign ack_1    = ack & ~sel;
  assign ack_4    = ack &  sel;
  assign cur_prod = sel ? prod_4 : prod_1;
  assign cur_done = sel ? done_4 : done_1;
  assign cur_rack = sel ? rack_4 : rack_1;
  assign cur_busy = sel ? busy_4 : busy_1;

  mult_seq_param #(.WIDTH(32), .STEP(1)) dut1 (
    .clk(clk), .reset(reset), .a(a), .b(b), .signed_mode(signed_mode),
    .valid_data(valid_1), .ack(ack_1), .producto(prod_1),
    .Done_Flag(done_1), .ret_ack(rack_1), .busy(busy_1)
  );

  mult_seq_param #(.WIDTH(32), .STEP(4)) dut4 (
    .clk(clk), .reset(reset), .a(a), .b(b), .signed_mode(signed_mode),
    .valid_data(valid_4), .ack(ack_4), .producto(prod_4),
    .Done_Flag(done_4), .ret_ack(rack_4), .busy(busy_4)
  );

  // Reference model: the exact product as plain integer arithmetic.
  function automatic logic [63:0] ref_mult(input logic [31:0] av, input logic [31:0] bv,
                                           input logic sm);
    longint sa, sb;
    if (sm) begin
      sa = longint'($signed(av));
      sb = longint'($signed(bv));
      return 64'(sa * sb);
    end
    return {32'd0, av} * {32'd0, bv};
  endfunction

  // Reference latency in edges after capture, counted up to Done_Flag.
  function automatic int ref_latency(input logic [31:0] bv, input logic sm, input int step);
    logic [31:0] mag;
    int h;
    int early;
    mag = (sm && bv[31]) ? -bv : bv;
    h = -1;
    for (int i = 0; i < 32; i++) if (mag[i]) h = i;
    early = (h < 0) ? 1 : (h + step) / step;
    return EARLY ? early : 32 / step;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic [31:0] av, input logic [31:0] bv,
                               input logic sm);
    sel         = s;
    a           = av;
    b           = bv;
    signed_mode = sm;
    valid_data  = 1'b1;
  endtask

  // Wait for Done_Flag, counting edges. The count is capped at 200, so a
  // stuck DUT shows up as a latency mismatch instead of a hang.
  task automatic waitDone(input bit scramble, output int lat);
    lat = 0;
    while (!cur_done && lat < 200) begin
      if (scramble) begin
        a           = $urandom;
        b           = $urandom;
        signed_mode = 1'($urandom_range(0, 1));
      end
      tick();
      lat++;
    end
  endtask

  task automatic finishAck(input string tag, input logic [63:0] exp_prod);
    tick();
    checkOutput({tag, "_hold_done"}, 64'(cur_done), 64'd1);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    checkOutput({tag, "_ack_done"}, 64'(cur_done), 64'd0);
    checkOutput({tag, "_ack_busy"}, 64'(cur_busy), 64'd0);
    checkOutput({tag, "_kept_prod"}, cur_prod, exp_prod);
  endtask

  // Run one full transaction: capture, calculation (with the operand buses
  // changing underneath it), completion, and ack.
  task automatic doOp(input logic s, input logic [31:0] av, input logic [31:0] bv,
                      input logic sm, input logic [63:0] exp_prod, input string tag);
    int lat;
    int exp_lat;
    exp_lat = ref_latency(bv, sm, s ? 4 : 1);
    applyStimulus(s, av, bv, sm);
    tick();
    valid_data = 1'b0;
    checkOutput({tag, "_ret_ack"}, 64'(cur_rack), 64'd1);
    checkOutput({tag, "_busy"}, 64'(cur_busy), 64'd1);
    waitDone(1'b1, lat);
    checkOutput({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    checkOutput({tag, "_prod"}, cur_prod, exp_prod);
    checkOutput({tag, "_no_rack_at_done"}, 64'(cur_rack), 64'd0);
    finishAck(tag, exp_prod);
  endtask

  initial begin
    int lat;
    int pulses;
    logic [31:0] ra, rb;
    logic rs;

    reset = 1'b1; a = '0; b = '0; signed_mode = 1'b0;
    valid_data = 1'b0; ack = 1'b0; sel = 1'b0;
    repeat (3) tick();

    // Reset state of both instances.
    checkOutput("rst_prod1", prod_1, 64'd0);
    checkOutput("rst_done1", 64'(done_1), 64'd0);
    checkOutput("rst_rack1", 64'(rack_1), 64'd0);
    checkOutput("rst_busy1", 64'(busy_1), 64'd0);
    checkOutput("rst_prod4", prod_4, 64'd0);
    checkOutput("rst_busy4", 64'(busy_4), 64'd0);
    reset = 1'b0;
    tick();

    // Directed unsigned and signed cases with spec-given constants.
    doOp(1'b0, 32'd10, 32'd10, 1'b0, 64'd100, "u10x10");
    doOp(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001, "umax");
    doOp(1'b0, 32'd19347, 32'd0, 1'b0, 64'd0, "ubzero");
    doOp(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 64'd1, "sm1xm1");
    doOp(1'b0, 32'h8000_0000, 32'd1, 1'b1, 64'hFFFF_FFFF_8000_0000, "sminx1");
    doOp(1'b0, 32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000, "sminxmin");
    doOp(1'b1, 32'd123456, 32'd654321, 1'b0, 64'd80779853376, "step4");
    doOp(1'b0, 32'd7, 32'd10, 1'b0, 64'd70, "early_b10");
    doOp(1'b1, 32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000, "s4min");

    // Randomized operations on both instances against the model.
    for (int i = 0; i < 24; i++) begin
      ra = $urandom;
      rb = $urandom;
      if (i % 6 == 3) rb = rb >> $urandom_range(0, 31);
      rs = 1'($urandom_range(0, 1));
      doOp(1'(i % 2), ra, rb, rs, ref_mult(ra, rb, rs), $sformatf("rnd%0d", i));
    end

    // Keep valid_data high through CALC and DONE: there should be exactly
    // one capture. Then ack together with valid_data returns to IDLE and the
    // block recaptures on the next edge.
    applyStimulus(1'b0, 32'd1234567, 32'h8000_0001, 1'b0);
    pulses = 0;
    tick();
    if (cur_rack) pulses++;
    lat = 0;
    while (!cur_done && lat < 200) begin
      tick();
      lat++;
      if (cur_rack) pulses++;
    end
    checkOutput("hold_pulses", 64'(pulses), 64'd1);
    checkOutput("hold_latency", 64'(lat), 64'(ref_latency(32'h8000_0001, 1'b0, 1)));
    checkOutput("hold_prod", cur_prod, ref_mult(32'd1234567, 32'h8000_0001, 1'b0));
    ack = 1'b1;
    tick();
    ack = 1'b0;
    checkOutput("ackvalid_done", 64'(cur_done), 64'd0);
    checkOutput("ackvalid_busy", 64'(cur_busy), 64'd0);
    checkOutput("ackvalid_rack", 64'(cur_rack), 64'd0);
    b = 32'd3;
    tick();
    valid_data = 1'b0;
    checkOutput("recapture_rack", 64'(cur_rack), 64'd1);
    checkOutput("recapture_busy", 64'(cur_busy), 64'd1);
    waitDone(1'b0, lat);
    checkOutput("recapture_latency", 64'(lat), 64'(ref_latency(32'd3, 1'b0, 1)));
    checkOutput("recapture_prod", cur_prod, 64'd3703701);
    finishAck("recapture", 64'd3703701);

    // ack asserted during CALC must be ignored.
    applyStimulus(1'b1, 32'hDEAD_BEEF, 32'h8000_0005, 1'b0);
    tick();
    valid_data = 1'b0;
    ack = 1'b1;
    repeat (3) tick();
    ack = 1'b0;
    checkOutput("ackcalc_done", 64'(cur_done), 64'd0);
    checkOutput("ackcalc_busy", 64'(cur_busy), 64'd1);
    waitDone(1'b1, lat);
    checkOutput("ackcalc_latency", 64'(lat + 3), 64'd8);
    checkOutput("ackcalc_prod", cur_prod, ref_mult(32'hDEAD_BEEF, 32'h8000_0005, 1'b0));
    finishAck("ackcalc", ref_mult(32'hDEAD_BEEF, 32'h8000_0005, 1'b0));

    // Reset at E0+10 in the middle of CALC.
    applyStimulus(1'b0, 32'h1234, 32'h8000_0003, 1'b0);
    tick();
    valid_data = 1'b0;
    repeat (9) tick();
    checkOutput("midrst_pre_done", 64'(cur_done), 64'd0);
    checkOutput("midrst_pre_busy", 64'(cur_busy), 64'd1);
    reset = 1'b1;
    tick();
    checkOutput("midrst_prod", cur_prod, 64'd0);
    checkOutput("midrst_done", 64'(cur_done), 64'd0);
    checkOutput("midrst_rack", 64'(cur_rack), 64'd0);
    checkOutput("midrst_busy", 64'(cur_busy), 64'd0);
    reset = 1'b0;
    tick();
    checkOutput("midrst_idle_busy", 64'(cur_busy), 64'd0);
    doOp(1'b0, 32'd55555, 32'd77777, 1'b0, 64'd4320901235, "after_rst");
    doOp(1'b0, 32'd99, 32'd0, 1'b1, 64'd0, "early_b0");

    $display("[TB] directed and random sequence complete");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
